// File: rtl/vgac_param.sv
// Parameterised VGA timing controller with pixel-RAM read pipeline and aligned syncs.
// Optional built-in colour-bar generator enabled by macro VGAC_TEST_PATTERN_EN (adds tp_en).
module vgac_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 4,
  parameter int RD_LAT   = 1
) (
  input  logic            vga_clk,
  input  logic            clrn,
  input  logic            en,
`ifdef VGAC_TEST_PATTERN_EN
  input  logic            tp_en,
`endif
  input  logic [3*CW-1:0] d_in,
  output logic [9:0]      row_addr,
  output logic [10:0]     col_addr,
  output logic            rdn,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            line_start,
  output logic            frame_start
);

  localparam logic [11:0] H_LAST      = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_LAST      = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] BAR_DIV     = 11'((H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1);
  localparam int          LAST        = RD_LAT - 1;

  // Colour bar index -> {r,g,b} on/off: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    logic [2:0] c;
    case (bar)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  logic [11:0] h_count, v_count;
  logic        act_s, hsync_s, vsync_s, row0_s, tp_mode;
  logic [10:0] col_calc, bar_q;
  logic [9:0]  row_calc;
  logic [2:0]  bar_s, tp_rgb;

  logic       act_p  [RD_LAT];
  logic       hs_p   [RD_LAT];
  logic       vs_p   [RD_LAT];
  logic       row0_p [RD_LAT];
  logic       tp_p   [RD_LAT];
  logic [2:0] bar_p  [RD_LAT];

`ifdef VGAC_TEST_PATTERN_EN
  assign tp_mode = tp_en;
`else
  assign tp_mode = 1'b0;
`endif

  // Horizontal/vertical counters; en low parks both at the origin.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h_count <= 12'd0;
      v_count <= 12'd0;
    end else if (!en) begin
      h_count <= 12'd0;
      v_count <= 12'd0;
    end else if (h_count == H_LAST) begin
      h_count <= 12'd0;
      if (v_count == V_LAST) v_count <= 12'd0;
      else                   v_count <= v_count + 12'd1;
    end else begin
      h_count <= h_count + 12'd1;
    end
  end

  // Region decode of the current count state; everything is idle while disabled.
  always_comb begin
    col_calc = 11'(h_count - H_ACT_START);
    row_calc = 10'(v_count - V_ACT_START);
    act_s    = en && (h_count >= H_ACT_START) && (h_count < H_ACT_END) &&
               (v_count >= V_ACT_START) && (v_count < V_ACT_END);
    hsync_s  = en && (h_count < H_SYNC_END);
    vsync_s  = en && (v_count < V_SYNC_END);
    row0_s   = (v_count == V_ACT_START);
    bar_q    = col_calc / BAR_DIV;
    if (bar_q > 11'd7) bar_s = 3'd7;
    else               bar_s = bar_q[2:0];
  end

  // Stage 1 (RAM address/strobe) followed by RD_LAT-1 delay stages matching RAM latency.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rdn      <= 1'b1;
      col_addr <= 11'd0;
      row_addr <= 10'd0;
      for (int i = 0; i < RD_LAT; i++) begin
        act_p[i]  <= 1'b0;
        hs_p[i]   <= 1'b0;
        vs_p[i]   <= 1'b0;
        row0_p[i] <= 1'b0;
        tp_p[i]   <= 1'b0;
        bar_p[i]  <= 3'd0;
      end
    end else begin
      rdn       <= ~(act_s & ~tp_mode);
      col_addr  <= act_s ? col_calc : 11'd0;
      row_addr  <= act_s ? row_calc : 10'd0;
      act_p[0]  <= act_s;
      hs_p[0]   <= hsync_s;
      vs_p[0]   <= vsync_s;
      row0_p[0] <= row0_s;
      tp_p[0]   <= tp_mode;
      bar_p[0]  <= bar_s;
      for (int i = 1; i < RD_LAT; i++) begin
        act_p[i]  <= act_p[i-1];
        hs_p[i]   <= hs_p[i-1];
        vs_p[i]   <= vs_p[i-1];
        row0_p[i] <= row0_p[i-1];
        tp_p[i]   <= tp_p[i-1];
        bar_p[i]  <= bar_p[i-1];
      end
    end
  end

  assign tp_rgb = bar_rgb(bar_p[LAST]);

  // Output stage: RAM data capture plus syncs/pulses, all on the same edge.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      de          <= act_p[LAST];
      hs          <= hs_p[LAST] ? HS_POL : ~HS_POL;
      vs          <= vs_p[LAST] ? VS_POL : ~VS_POL;
      line_start  <= act_p[LAST] & ~de;
      frame_start <= act_p[LAST] & ~de & row0_p[LAST];
      if (!act_p[LAST]) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else if (tp_p[LAST]) begin
        r <= {CW{tp_rgb[2]}};
        g <= {CW{tp_rgb[1]}};
        b <= {CW{tp_rgb[0]}};
      end else begin
        r <= d_in[CW-1:0];
        g <= d_in[2*CW-1:CW];
        b <= d_in[3*CW-1:2*CW];
      end
    end
  end

endmodule

// File: doc/vgac_param.md
VGAC_PARAM -- requirements
Module: vgac_param

Interface
REQ-001 Parameter H_ACTIVE, 640: active pixels per line.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in clocks.
REQ-003 Parameter V_ACTIVE, 480: active lines per frame.
REQ-004 Parameters V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync and back porch widths in lines.
REQ-005 Parameters HS_POL 0 and VS_POL 0: sync polarity (0 = active-low, 1 = active-high).
REQ-006 Parameter CW, 4: bits per colour channel.
REQ-007 Parameter RD_LAT, 1: pixel-RAM read latency in clocks (legal range 1..4).
REQ-008 vga_clk  in  1  pixel clock; clrn  in  1  reset, asynchronous, active-low; clock vga_clk.
REQ-009 en  in  1  timing enable.
REQ-010 d_in  in  3*CW  pixel data, {b,g,r}.
REQ-011 row_addr  out  10  pixel-RAM row address; col_addr  out  11  pixel-RAM column address.
REQ-012 rdn  out  1  pixel-RAM read strobe, active-low.
REQ-013 hs  out  1  horizontal sync; vs  out  1  vertical sync.
REQ-014 de  out  1  display enable; r, g, b  out  CW each  colour outputs.
REQ-015 line_start  out  1  one-clock pulse; frame_start  out  1  one-clock pulse.

Function
REQ-016 h_count shall run 0..H_TOTAL-1 and wrap, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
REQ-017 v_count shall advance on h_count wrap and run 0..V_TOTAL-1, wrapping the same way.
REQ-018 Region order shall be: sync at [0, SYNC), back porch, active at [SYNC+BP, SYNC+BP+ACTIVE), then front porch.
REQ-019 Stage 1 (one clock after a count state) shall register the following:
- rdn = 0 only when both counters are in their active region.
- col_addr = h_count-(H_SYNC+H_BP) and row_addr = v_count-(V_SYNC+V_BP) while active.
- Both addresses = 0 while not active.
REQ-020 The block shall sample d_in RD_LAT clocks after stage 1 and register it into r/g/b/de at that same edge.
REQ-021 The r/g/b/de edge shall be RD_LAT+1 clocks after the count state.
REQ-022 hs and vs shall be delayed by RD_LAT+1 clocks so hs, vs, de, r, g and b are mutually aligned.
REQ-023 hs and vs shall be at active level during their sync regions and inactive level otherwise.
REQ-024 de shall be the delayed ~rdn.
REQ-025 r/g/b shall be 0 whenever de = 0.
REQ-026 line_start shall pulse with every de rising edge.
REQ-027 frame_start shall pulse with the de rising edge of active line 0 only.
REQ-028 en = 0 shall synchronously clear both counters to 0 and drain the pipeline to idle; see REQ-032 for the idle values.
REQ-029 On en = 1 after en = 0, counting shall resume from h = 0, v = 0.
REQ-030 Address arithmetic shall be unsigned and truncated to port width; no wrap values shall appear outside the active region.

Reset
REQ-031 clrn low shall asynchronously clear all counters and pipeline registers.
REQ-032 Under reset, outputs shall be: rdn = 1, de = 0, r/g/b = 0, row_addr = col_addr = 0, line_start = frame_start = 0.
REQ-033 Under reset, hs shall be ~HS_POL and vs shall be ~VS_POL (inactive level).
REQ-034 After clrn rises, the first counter state shall be h = 0, v = 0.

Configuration
REQ-035 Macro VGAC_TEST_PATTERN_EN defined shall add input port tp_en (1 bit).
REQ-036 With the macro defined and tp_en = 1, d_in shall be ignored and rdn shall be held at 1.
REQ-037 In the same mode, active pixels shall show 8 vertical bars, each H_ACTIVE/8 wide, coloured white, yellow, cyan, green, magenta, red, blue, black (full-scale channels).
REQ-038 In the same mode, de, hs, vs and the pulse timing shall be unchanged.
REQ-039 With the macro undefined, the tp_en port shall not exist and d_in shall always be used.

Verification
REQ-040 Defaults, release reset, en = 1 -> hs period 800 clocks, low for 96; vs period 420000 clocks, low for 1600; hs/vs edges aligned with de timeline.
REQ-041 Defaults -> first rdn = 0 at count h = 144, v = 35 with row/col = 0/0; last at h = 783, v = 514 with col 639, row 479; rdn low 307200 clocks per frame.
REQ-042 d_in = 12'hABC constant -> de high exactly 640 clocks per line; r = C, g = B, b = A during de, 0 otherwise; de rises RD_LAT = 1 clock after rdn falls; line_start 480 pulses and frame_start 1 pulse per frame.
REQ-043 RD_LAT = 3, HS_POL = 1 -> hs active-high with 96-clock width; rdn fall to de rise = 3 clocks; hs-to-de spacing identical to the default configuration.
REQ-044 clrn pulsed low at h = 400, v = 100 -> all outputs take reset values immediately without a clock edge; en low for 10 clocks then high -> first active pixel 144 clocks + 35 lines later.
REQ-045 VGAC_TEST_PATTERN_EN defined, tp_en = 1 -> columns 0..79 give r = g = b = F, columns 560..639 give 0, columns 80..159 give r = g = F and b = 0; rdn stays 1.
